// File: rtl/max_subtract_stream.sv
// Streaming max-subtraction stage: buffers a LEN-element vector, finds its maximum,
// then replays (x - max) rescaled to OUT_FRAC bits. Optional floor clamp: SUBMAX_CLAMP_EN.
module max_subtract_stream #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 8,
    parameter int LEN       = 32,
    parameter int IN_FRAC   = 14,
    parameter int OUT_FRAC  = 12,
    parameter int CLAMP_MIN = -12288
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [N-1:0][BIT_WIDTH-1:0]   i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [N-1:0][BIT_WIDTH-1:0]   o_data,
    output logic                          o_last,
    output logic [BIT_WIDTH-1:0]          o_max
);

    localparam int BEATS = LEN / N;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SHIFT = IN_FRAC - OUT_FRAC;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RESOLVE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    if ((LEN % N) != 0 || IN_FRAC < OUT_FRAC || CLAMP_MIN > 0 || (N & (N - 1)) != 0) begin : g_cfg_err
        $error("max_subtract_stream: invalid parameter set");
    end

    // Diff is always <= 0, so only the negative rail can saturate in practice.
    function automatic logic [BIT_WIDTH-1:0] sub_lane(input logic [BIT_WIDTH-1:0] x,
                                                       input logic [BIT_WIDTH-1:0] m);
        logic signed [BIT_WIDTH:0] diff;
        logic signed [BIT_WIDTH:0] shd;
        logic [BIT_WIDTH-1:0]      res;
        diff = $signed({x[BIT_WIDTH-1], x}) - $signed({m[BIT_WIDTH-1], m});
        shd  = diff >>> SHIFT;
        if (shd[BIT_WIDTH] != shd[BIT_WIDTH-1]) begin
            res = shd[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end else begin
            res = shd[BIT_WIDTH-1:0];
        end
`ifdef SUBMAX_CLAMP_EN
        if ($signed(res) < $signed(BIT_WIDTH'(CLAMP_MIN))) begin
            res = BIT_WIDTH'(CLAMP_MIN);
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    state_t                                  r_state;
    state_t                                  w_state_nxt;
    logic [BEATS-1:0][N-1:0][BIT_WIDTH-1:0]  r_buf;
    logic [CW-1:0]                           r_beat_cnt;
    logic [CW-1:0]                           r_emit_cnt;
    logic                                    r_emit_done;
    logic                                    r_res_cnt;
    logic                                    r_bmax_vld;
    logic                                    r_bmax_first;
    logic signed [BIT_WIDTH-1:0]             r_beat_max;
    logic signed [BIT_WIDTH-1:0]             r_run_max;
    logic signed [BIT_WIDTH-1:0]             w_tree [2*N-1];
    logic [N-1:0][BIT_WIDTH-1:0]             w_lanes;
    logic                                    w_accept;
    logic                                    w_fire;
    logic                                    w_load;

    assign o_ready  = (r_state == COLLECT);
    assign o_max    = r_run_max;
    assign w_accept = i_valid && o_ready;
    assign w_fire   = o_valid && i_ready;
    assign w_load   = (r_state == EMIT) && !r_emit_done && (!o_valid || i_ready);

    // Lane-max tree in heap layout: leaves at N-1..2N-2, root at index 0.
    always_comb begin
        for (int i = 0; i < 2*N-1; i++) begin
            w_tree[i] = {BIT_WIDTH{1'b0}};
        end
        for (int l = 0; l < N; l++) begin
            w_tree[N-1+l] = i_data[l];
        end
        for (int i = N-2; i >= 0; i--) begin
            w_tree[i] = (w_tree[2*i+1] > w_tree[2*i+2]) ? w_tree[2*i+1] : w_tree[2*i+2];
        end
    end

    // Per-lane subtract/rescale of the buffered beat about to be emitted.
    always_comb begin
        for (int l = 0; l < N; l++) begin
            w_lanes[l] = sub_lane(r_buf[r_emit_cnt][l], r_run_max);
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: begin
                if (w_accept && (r_beat_cnt == LAST_BEAT)) w_state_nxt = RESOLVE;
                else                                        w_state_nxt = r_state;
            end
            RESOLVE: begin
                if (r_res_cnt) w_state_nxt = EMIT;
                else           w_state_nxt = r_state;
            end
            EMIT: begin
                if (w_fire && o_last) w_state_nxt = COLLECT;
                else                  w_state_nxt = r_state;
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Collection side: buffer fill, per-beat max, running max one cycle behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf        <= {(BEATS*N*BIT_WIDTH){1'b0}};
            r_beat_cnt   <= CNT_ZERO;
            r_beat_max   <= {BIT_WIDTH{1'b0}};
            r_run_max    <= {BIT_WIDTH{1'b0}};
            r_bmax_vld   <= 1'b0;
            r_bmax_first <= 1'b0;
            r_res_cnt    <= 1'b0;
        end else begin
            r_bmax_vld   <= w_accept;
            r_bmax_first <= (r_beat_cnt == CNT_ZERO);
            r_res_cnt    <= (r_state == RESOLVE) ? ~r_res_cnt : 1'b0;
            if (w_accept) begin
                r_buf[r_beat_cnt] <= i_data;
                r_beat_max        <= w_tree[0];
                r_beat_cnt        <= (r_beat_cnt == LAST_BEAT) ? CNT_ZERO : r_beat_cnt + CW'(1);
            end
            if (r_bmax_vld) begin
                if (r_bmax_first || (r_beat_max > r_run_max)) r_run_max <= r_beat_max;
            end
        end
    end

    // Emit side: output register with hold under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_data      <= {(N*BIT_WIDTH){1'b0}};
            r_emit_cnt  <= CNT_ZERO;
            r_emit_done <= 1'b0;
        end else if (w_fire && o_last) begin
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            r_emit_cnt  <= CNT_ZERO;
            r_emit_done <= 1'b0;
        end else if (w_load) begin
            o_valid <= 1'b1;
            o_data  <= w_lanes;
            o_last  <= (r_emit_cnt == LAST_BEAT);
            if (r_emit_cnt == LAST_BEAT) r_emit_done <= 1'b1;
            else                         r_emit_cnt  <= r_emit_cnt + CW'(1);
        end else if (w_fire) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_subtract_stream.sv
// Randomized bench for max_subtract_stream with a floor-division reference model and scoreboard.
module tb_max_subtract_stream;

    localparam int BW        = 16;
    localparam int N         = 8;
    localparam int LEN       = 32;
    localparam int BEATS     = LEN / N;
    localparam int Q         = 4;        // 2^(IN_FRAC-OUT_FRAC)
    localparam int CLAMP_MIN = -12288;

    typedef struct {
        logic [N*BW-1:0] data;
        logic            last;
        logic [BW-1:0]   mx;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_valid = 1'b0;
    logic                   i_ready = 1'b1;
    logic                   o_ready, o_valid, o_last;
    logic [N-1:0][BW-1:0]   i_data = '0;
    logic [N-1:0][BW-1:0]   o_data;
    logic [BW-1:0]          o_max;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          last_hs_cyc = 0;
    int          stall_left = 0;
    bit          rdy_rand = 1'b0;
    logic [BW-1:0] vec [LEN];
    logic [BW-1:0] vec2 [LEN];
    logic [BW-1:0] t1 [N];

    max_subtract_stream dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_last(o_last), .o_max(o_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: max over the vector, then floor((x-max)/Q), saturate, optional floor.
    task automatic push_expected(input logic [BW-1:0] v [LEN]);
        int   mx, d, r;
        exp_t t;
        mx = int'($signed(v[0]));
        for (int e = 1; e < LEN; e++)
            if (int'($signed(v[e])) > mx) mx = int'($signed(v[e]));
        for (int b = 0; b < BEATS; b++) begin
            for (int l = 0; l < N; l++) begin
                d = int'($signed(v[b*N+l])) - mx;
                r = (d >= 0) ? d / Q : -((-d + Q - 1) / Q);
                if (r > 32767)  r = 32767;
                if (r < -32768) r = -32768;
`ifdef SUBMAX_CLAMP_EN
                if (r < CLAMP_MIN) r = CLAMP_MIN;
`endif
                t.data[l*BW +: BW] = r[BW-1:0];
            end
            t.last = (b == BEATS-1);
            t.mx   = mx[BW-1:0];
            exp_q.push_back(t);
        end
    endtask

    task automatic send_vec(input logic [BW-1:0] v [LEN], input int nbeats, input int gap_max,
                            input bit chk_b2b);
        bit acc;
        int waited;
        for (int b = 0; b < nbeats; b++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    i_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            i_valid = 1'b1;
            for (int l = 0; l < N; l++) i_data[l] = v[b*N+l];
            acc = 1'b0;
            waited = 0;
            while (!acc) begin
                @(negedge clk);
                acc = o_ready;
                @(posedge clk); #1;
                waited++;
                if (!acc && waited > 200) begin
                    check_value("accept_timeout", 160'd0, 160'd1);
                    return;
                end
            end
            if (chk_b2b && b == 0) check_value("b2b_gap", 160'(cyc - last_hs_cyc), 160'd1);
        end
        if (nbeats == BEATS) begin
            last_acc_cyc = cyc;
            push_expected(v);
        end
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_value("drain", 160'(exp_q.size()), 160'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                i_ready = 1'b0;
                stall_left--;
            end else if (rdy_rand) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard, hold-stability, latency, ready-low during emit.
    initial begin
        logic [145:0] prev;
        bit prev_stall = 1'b0;
        bit prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_valid) check_value("ready_low_emit", 160'(o_ready), 160'd0);
                if (prev_stall)
                    check_value("hold_stable", 160'({o_valid, o_last, o_max, o_data}), 160'(prev));
                if (o_valid && !prev_valid)
                    check_value("first_out_latency", 160'(cyc - last_acc_cyc), 160'd3);
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check_value("unexpected_beat", 160'd1, 160'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_value("o_data", 160'(o_data), 160'(e.data));
                        check_value("o_last", 160'(o_last), 160'(e.last));
                        check_value("o_max", 160'(o_max), 160'(e.mx));
                    end
                    if (o_last) last_hs_cyc = cyc + 1;
                end
                prev_stall = o_valid && !i_ready;
                prev       = {o_valid, o_last, o_max, o_data};
                prev_valid = o_valid;
            end else begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #2;
        check_value("rst_o_valid", 160'(o_valid), 160'd0);
        check_value("rst_o_ready", 160'(o_ready), 160'd1);
        check_value("rst_o_last", 160'(o_last), 160'd0);
        check_value("rst_o_data", 160'(o_data), 160'd0);
        check_value("rst_o_max", 160'(o_max), 160'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Mixed first beat, rest zero; max is 0x7FFF in lane 3.
        t1 = '{16'h6000, 16'hF000, 16'h3000, 16'h7FFF, 16'hC000, 16'h4000, 16'h0000, 16'hE000};
        for (int e = 0; e < LEN; e++) vec[e] = (e < N) ? t1[e] : 16'h0000;
        send_vec(vec, BEATS, 0, 1'b0);
        i_valid = 1'b0;
        wait_drain();

        // Maximum only in the final lane of the final beat.
        for (int e = 0; e < LEN; e++) vec[e] = 16'hC000;
        vec[LEN-1] = 16'h4000;
        send_vec(vec, BEATS, 0, 1'b0);
        i_valid = 1'b0;
        wait_drain();

        // Extremes: most negative input against near-maximum.
        for (int e = 0; e < LEN; e++) vec[e] = 16'($urandom_range(0, 65535));
        vec[3]  = 16'h8000;
        vec[20] = 16'h7FFF;
        send_vec(vec, BEATS, 0, 1'b0);
        i_valid = 1'b0;
        wait_drain();

        // All-equal vector.
        for (int e = 0; e < LEN; e++) vec[e] = 16'h1234;
        send_vec(vec, BEATS, 0, 1'b0);
        i_valid = 1'b0;
        wait_drain();

        // Backpressure: three stalled cycles once the first beat is out.
        for (int e = 0; e < LEN; e++) vec[e] = 16'($urandom_range(0, 65535));
        send_vec(vec, BEATS, 0, 1'b0);
        i_valid = 1'b0;
        begin
            int cnt = 0;
            while (!o_valid && cnt < 50) begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        stall_left = 3;
        wait_drain();

        // Reset after two beats; discarded beats must not affect the next vector.
        for (int e = 0; e < LEN; e++) vec[e] = 16'h7000;
        send_vec(vec, 2, 0, 1'b0);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("midrst_o_valid", 160'(o_valid), 160'd0);
        check_value("midrst_o_ready", 160'(o_ready), 160'd1);
        check_value("midrst_o_max", 160'(o_max), 160'd0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 0; e < LEN; e++) vec[e] = 16'($urandom_range(0, 16383)) - 16'd8192;
        send_vec(vec, BEATS, 0, 1'b0);
        i_valid = 1'b0;
        wait_drain();

        // Back-to-back vectors with i_valid held high.
        for (int e = 0; e < LEN; e++) vec[e]  = 16'($urandom_range(0, 65535));
        for (int e = 0; e < LEN; e++) vec2[e] = 16'($urandom_range(0, 65535));
        send_vec(vec, BEATS, 0, 1'b0);
        send_vec(vec2, BEATS, 0, 1'b1);
        i_valid = 1'b0;
        wait_drain();

        // Random vectors, random input gaps and random downstream ready.
        rdy_rand = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int e = 0; e < LEN; e++) vec[e] = 16'($urandom_range(0, 65535));
            send_vec(vec, BEATS, 2, 1'b0);
        end
        i_valid = 1'b0;
        wait_drain();
        rdy_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
